// File: rtl/riscv_bitops_seq.sv
// Iterative POPCNT/CLZ/CTZ/BREV unit, BITS_PER_CYCLE bits per busy cycle; valid_o pulses N+1 edges after accept.
// No backpressure on the result: ready_o is high only in IDLE, and kill_i aborts in-flight work without a completion.
module riscv_bitops_seq #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 8,
   parameter int OP_WIDTH       = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable_i,
   input  logic [OP_WIDTH-1:0] operator_i,
   input  logic [WIDTH-1:0]    operand_a_i,
   input  logic                kill_i,
   output logic                ready_o,
   output logic                valid_o,
   output logic [WIDTH-1:0]    result_o
);

   localparam int N    = WIDTH / BITS_PER_CYCLE;
   localparam int CNTW = $clog2(N) + 1;
   localparam int CW   = $clog2(WIDTH) + 1;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   localparam logic [OP_WIDTH-1:0] OP_POPCNT = OP_WIDTH'(0);
   localparam logic [OP_WIDTH-1:0] OP_CLZ    = OP_WIDTH'(1);
   localparam logic [OP_WIDTH-1:0] OP_CTZ    = OP_WIDTH'(2);

   generate
      if ((WIDTH < 2) || (WIDTH % BITS_PER_CYCLE != 0)) begin : g_bad_param
         $error("riscv_bitops_seq: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
      end
   endgenerate

   logic [0:0]          state_q,  state_d;
   logic [CNTW-1:0]     cnt_q,    cnt_d;
   logic [WIDTH-1:0]    acc_q,    acc_d;
   logic                found_q,  found_d;
   logic [OP_WIDTH-1:0] op_q,     op_d;
   logic [WIDTH-1:0]    opnd_q,   opnd_d;
   logic [WIDTH-1:0]    result_q, result_d;
   logic                valid_q,  valid_d;

   logic [CNTW-1:0]           rd_idx;
   logic [BITS_PER_CYCLE-1:0] chunk;
   logic [BITS_PER_CYCLE-1:0] chunk_rev;
   logic [CW-1:0]             chunk_pc;
   logic [CW-1:0]             chunk_lz;
   logic [CW-1:0]             chunk_tz;

   // CLZ walks the operand from the top chunk down; everything else goes LSB-first.
   always_comb begin
      rd_idx = (op_q == OP_CLZ) ? (CNTW'(N - 1) - cnt_q) : cnt_q;
      chunk  = '0;
      for (int k = 0; k < N; k++) begin
         if (rd_idx == CNTW'(k)) chunk = opnd_q[k*BITS_PER_CYCLE +: BITS_PER_CYCLE];
      end
   end

   always_comb begin
      chunk_pc  = '0;
      chunk_lz  = CW'(BITS_PER_CYCLE);
      chunk_tz  = CW'(BITS_PER_CYCLE);
      chunk_rev = '0;
      for (int b = 0; b < BITS_PER_CYCLE; b++) begin
         chunk_pc     = chunk_pc + CW'(chunk[b]);
         chunk_rev[b] = chunk[BITS_PER_CYCLE-1-b];
         if (chunk[b]) chunk_lz = CW'(BITS_PER_CYCLE - 1 - b);
      end
      for (int b = BITS_PER_CYCLE - 1; b >= 0; b--) begin
         if (chunk[b]) chunk_tz = CW'(b);
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      found_d  = found_q;
      op_d     = op_q;
      opnd_d   = opnd_q;
      result_d = result_q;
      valid_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (enable_i && !kill_i) begin
               state_d = S_BUSY;
               cnt_d   = '0;
               acc_d   = '0;
               found_d = 1'b0;
               op_d    = operator_i;
               opnd_d  = operand_a_i;
            end
         end
         S_BUSY: begin
            if (kill_i) begin
               state_d = S_IDLE;
            end else begin
               case (op_q)
                  OP_POPCNT: acc_d = acc_q + WIDTH'(chunk_pc);
                  OP_CLZ: begin
                     if (!found_q) begin
                        acc_d   = acc_q + WIDTH'(chunk_lz);
                        found_d = |chunk;
                     end
                  end
                  OP_CTZ: begin
                     if (!found_q) begin
                        acc_d   = acc_q + WIDTH'(chunk_tz);
                        found_d = |chunk;
                     end
                  end
                  default: begin
                     for (int k = 0; k < N; k++) begin
                        if (cnt_q == CNTW'(k)) acc_d[(N-1-k)*BITS_PER_CYCLE +: BITS_PER_CYCLE] = chunk_rev;
                     end
                  end
               endcase
               cnt_d = cnt_q + CNTW'(1);
               if (cnt_q == CNTW'(N - 1)) begin
                  state_d  = S_IDLE;
                  result_d = acc_d;
                  valid_d  = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         found_q  <= 1'b0;
         op_q     <= '0;
         opnd_q   <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         found_q  <= found_d;
         op_q     <= op_d;
         opnd_q   <= opnd_d;
         result_q <= result_d;
         valid_q  <= valid_d;
      end
   end

   assign ready_o  = (state_q == S_IDLE);
   assign valid_o  = valid_q;
   assign result_o = result_q;

endmodule

// File: tb/tb_riscv_bitops_seq.sv
// Directed bench for riscv_bitops_seq: default 32/8 instance plus 32/1, 32/32 and 16/4 instances sharing one stimulus.
module tb_riscv_bitops_seq;

   logic        clk;
   logic        rst_n;

   logic        en0, kill0, rdy0, vld0;
   logic [1:0]  op0;
   logic [31:0] a0, res0;

   logic        s_en;
   logic [1:0]  s_op;
   logic [31:0] s_a;
   logic        rdy1, vld1, rdy2, vld2, rdy3, vld3;
   logic [31:0] res1, res2;
   logic [15:0] res3;

   int n_assert = 0;
   int n_fail   = 0;

   riscv_bitops_seq #(.WIDTH(32), .BITS_PER_CYCLE(8)) dut0 (
      .clk(clk), .rst_n(rst_n), .enable_i(en0), .operator_i(op0), .operand_a_i(a0),
      .kill_i(kill0), .ready_o(rdy0), .valid_o(vld0), .result_o(res0));

   riscv_bitops_seq #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .enable_i(s_en), .operator_i(s_op), .operand_a_i(s_a),
      .kill_i(1'b0), .ready_o(rdy1), .valid_o(vld1), .result_o(res1));

   riscv_bitops_seq #(.WIDTH(32), .BITS_PER_CYCLE(32)) dut2 (
      .clk(clk), .rst_n(rst_n), .enable_i(s_en), .operator_i(s_op), .operand_a_i(s_a),
      .kill_i(1'b0), .ready_o(rdy2), .valid_o(vld2), .result_o(res2));

   riscv_bitops_seq #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut3 (
      .clk(clk), .rst_n(rst_n), .enable_i(s_en), .operator_i(s_op), .operand_a_i(s_a[15:0]),
      .kill_i(1'b0), .ready_o(rdy3), .valid_o(vld3), .result_o(res3));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Bit-serial reference over the low w bits of a.
   function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a, input int w);
      logic [31:0] r;
      r = '0;
      case (op)
         2'd0: for (int i = 0; i < w; i++) r = r + 32'(a[i]);
         2'd1: for (int i = w - 1; i >= 0; i--) begin
                  if (a[i]) break;
                  r = r + 1;
               end
         2'd2: for (int i = 0; i < w; i++) begin
                  if (a[i]) break;
                  r = r + 1;
               end
         default: for (int i = 0; i < w; i++) r[w-1-i] = a[i];
      endcase
      return r;
   endfunction

   task automatic issue0(input logic [1:0] op, input logic [31:0] a);
      op0 = op;
      a0  = a;
      en0 = 1'b1;
      @(posedge clk); #1;
      en0 = 1'b0;
   endtask

   task automatic wait_valid(input int budget, output int k);
      k = -1;
      for (int i = 1; i <= budget; i++) begin
         @(posedge clk); #1;
         if (vld0) begin
            k = i;
            break;
         end
      end
   endtask

   task automatic watch_quiet(input string tag, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (vld0) seen = 1'b1;
      end
      check(tag, 32'(seen), 32'd0);
   endtask

   // valid_o is first seen after edge N (sampled at edge N+1), i.e. 4 for the default instance.
   task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] exp);
      int k;
      issue0(op, a);
      wait_valid(12, k);
      check(tag, res0, exp);
      check({tag, "_lat"}, 32'(k), 32'd4);
   endtask

   task automatic sweep(input string tag, input logic [1:0] op, input logic [31:0] a);
      int l1, l2, l3;
      logic [31:0] r1, r2;
      logic [15:0] r3;
      l1 = -1; l2 = -1; l3 = -1;
      r1 = '0; r2 = '0; r3 = '0;
      s_op = op;
      s_a  = a;
      s_en = 1'b1;
      @(posedge clk); #1;
      s_en = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (vld1 && l1 < 0) begin l1 = i; r1 = res1; end
         if (vld2 && l2 < 0) begin l2 = i; r2 = res2; end
         if (vld3 && l3 < 0) begin l3 = i; r3 = res3; end
      end
      check({tag, "_w32b1"}, r1, ref_op(op, a, 32));
      check({tag, "_w32b1_lat"}, 32'(l1), 32'd32);
      check({tag, "_w32b32"}, r2, ref_op(op, a, 32));
      check({tag, "_w32b32_lat"}, 32'(l2), 32'd1);
      check({tag, "_w16b4"}, {16'h0, r3}, ref_op(op, a, 16));
      check({tag, "_w16b4_lat"}, 32'(l3), 32'd4);
   endtask

   initial begin
      int k;
      logic [31:0] exp_b2b [3];
      logic [31:0] nxt_b2b [3];
      logic [31:0] ra;

      rst_n = 1'b0;
      en0 = 1'b0; kill0 = 1'b0; op0 = '0; a0 = '0;
      s_en = 1'b0; s_op = '0; s_a = '0;

      #12;
      check("rst_ready", 32'(rdy0), 32'd1);
      check("rst_valid", 32'(vld0), 32'd0);
      check("rst_result", res0, 32'd0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      do_op("popcnt", 2'd0, 32'hF0F0_0001, 32'd9);
      do_op("clz", 2'd1, 32'h0001_0000, 32'd15);
      do_op("ctz", 2'd2, 32'h0001_0000, 32'd16);
      do_op("brev", 2'd3, 32'h0000_0001, 32'h8000_0000);

      do_op("clz0", 2'd1, 32'h0, 32'd32);
      do_op("ctz0", 2'd2, 32'h0, 32'd32);
      do_op("popcnt_ones", 2'd0, 32'hFFFF_FFFF, 32'd32);
      do_op("brev_ones", 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

      // Back-to-back: enable held high, a new accept lands in each valid_o cycle.
      exp_b2b = '{32'd1, 32'd2, 32'd3};
      nxt_b2b = '{32'h3, 32'h7, 32'h0};
      op0 = 2'd0; a0 = 32'h1; en0 = 1'b1;
      @(posedge clk); #1;
      a0 = nxt_b2b[0];
      for (int i = 0; i < 3; i++) begin
         wait_valid(12, k);
         check($sformatf("b2b%0d_res", i), res0, exp_b2b[i]);
         check($sformatf("b2b%0d_lat", i), 32'(k), 32'd4);
         check($sformatf("b2b%0d_ready", i), 32'(rdy0), 32'd1);
         if (i == 2) en0 = 1'b0;
         @(posedge clk); #1;
         if (i < 2) begin
            check($sformatf("b2b%0d_accepted", i), 32'(rdy0), 32'd0);
            a0 = nxt_b2b[i+1];
         end
      end
      check("b2b_idle", 32'(rdy0), 32'd1);

      // Kill sampled at busy edge E2.
      issue0(2'd1, 32'h0000_00FF);
      @(posedge clk); #1;
      kill0 = 1'b1;
      @(posedge clk); #1;
      kill0 = 1'b0;
      check("kill_ready", 32'(rdy0), 32'd1);
      watch_quiet("kill_no_valid", 8);
      check("kill_result_held", res0, 32'd3);

      en0 = 1'b1; kill0 = 1'b1; op0 = 2'd0; a0 = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      check("kill_idle_no_accept", 32'(rdy0), 32'd1);
      en0 = 1'b0; kill0 = 1'b0;
      watch_quiet("kill_idle_no_valid", 6);
      check("kill_idle_result", res0, 32'd3);

      // Asynchronous reset in the middle of a POPCNT.
      issue0(2'd0, 32'hF0F0_0001);
      @(posedge clk); #1;
      #2 rst_n = 1'b0;
      #1;
      check("arst_result", res0, 32'd0);
      check("arst_valid", 32'(vld0), 32'd0);
      check("arst_ready", 32'(rdy0), 32'd1);
      #2 rst_n = 1'b1;
      watch_quiet("arst_no_valid", 8);
      do_op("arst_popcnt", 2'd0, 32'h5, 32'd2);

      sweep("sw_clz1", 2'd1, 32'h0000_0001);
      check("sw_clz1_w16_const", ref_op(2'd1, 32'h0000_0001, 16), 32'd15);
      for (int i = 0; i < 8; i++) begin
         ra = $urandom;
         if (i == 5) ra = ra & 32'h00F0_0000;
         sweep($sformatf("sw_rand%0d", i), 2'(i % 4), ra);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
